// File: rtl/object_list_pkg.sv
// Shared types and width helpers for the object_list block.
package object_list_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } iter_state_t;

  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/object_list_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
module object_list_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/object_list.sv
// Order-preserving object list with append insert and single-pass in-place update/remove.
// Optional sticky overflow flag enabled by defining OBJECT_LIST_OVERFLOW_EN.
//
//  state | meaning
//  IDLE  | accepting inserts, iter_done high
//  ITER  | presenting one element per cycle at rd_idx, compacting into wr_idx
module object_list
  import object_list_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce,
  input  logic                         clear,
  input  logic                         insert_en,
  input  logic [DATA_W-1:0]            insert_data,
  output logic                         insert_ready,
  input  logic                         iter_start,
  output logic                         iter_done,
  output logic                         iter_valid,
  output logic [DATA_W-1:0]            iter_out,
  input  logic [DATA_W-1:0]            iter_in,
  input  logic                         iter_remove,
  output logic [cnt_w(DEPTH)-1:0]      count,
  output logic                         full
`ifdef OBJECT_LIST_OVERFLOW_EN
  ,
  output logic                         overflow
`endif
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  iter_state_t       state, state_next;
  logic [IDX_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  wr_idx;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  start_len;
  logic [CNT_W-1:0]  wr_next;
  logic              accept_ins;
  logic              start_ok;
  logic              last;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign insert_ready = (state == IDLE) && (count < CNT_W'(DEPTH));
  assign accept_ins   = insert_en && insert_ready;
  // A same-cycle insert is counted into the pass it starts.
  assign start_len    = count + CNT_W'(accept_ins);
  assign start_ok     = iter_start && (start_len != '0);
  assign last         = (CNT_W'(rd_idx) == (len - CNT_W'(1)));
  assign wr_next      = wr_idx + CNT_W'(!iter_remove);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ce) begin
      if (clear) begin
        state_next = IDLE;
      end else begin
        case (state)
          IDLE:    if (start_ok) state_next = ITER;
          ITER:    if (last)     state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    iter_done  = (state == IDLE);
    iter_valid = (state == ITER);
    iter_out   = iter_valid ? mem_rdata : '0;
    full       = (count == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      rd_idx <= '0;
      wr_idx <= '0;
      len    <= '0;
    end else if (ce) begin
      if (clear) begin
        count  <= '0;
        rd_idx <= '0;
        wr_idx <= '0;
      end else if (state == IDLE) begin
        if (accept_ins) count <= count + CNT_W'(1);
        if (start_ok) begin
          rd_idx <= '0;
          wr_idx <= '0;
          len    <= start_len;
        end
      end else begin
        rd_idx <= rd_idx + IDX_W'(1);
        wr_idx <= wr_next;
        if (last) count <= wr_next;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = IDX_W'(count);
    mem_wdata = insert_data;
    if (rst_n && ce && !clear) begin
      if (state == IDLE) begin
        mem_we = accept_ins;
      end else begin
        mem_we    = !iter_remove;
        mem_waddr = IDX_W'(wr_idx);
        mem_wdata = iter_in;
      end
    end
  end

  object_list_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

`ifdef OBJECT_LIST_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                          overflow <= 1'b0;
    else if (ce && clear)                overflow <= 1'b0;
    else if (ce && insert_en && !insert_ready) overflow <= 1'b1;
  end
`endif

endmodule
